uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- UART transmitter: the transmit-side counterpart of the UART RX path, sharing that path's oversampled clock and prescale setting.
- Accepts one parallel word per handshake and sends a frame on TX_OUT: start bit, data bits LSB first, optional parity bit, stop bit.
- Each bit is held for exactly `prescale` clock cycles, so TX and RX use the same prescale value for the same baud rate.
- Sits between the system/FIFO read side and the serial line pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- CLK  input  1  oversampled UART clock, same clock as the RX path.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel word to send; sampled only on accept.
- Data_Valid  input  1  request to send P_DATA; honoured only in IDLE.
- PAR_EN  input  1  1 = parity bit inserted; sampled on accept.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
- prescale  input  6  clock cycles per bit; sampled on accept.
- TX_OUT  output  1  serial line, registered; idle level 1.
- Busy  output  1  registered; 1 from accept until the end of the stop bit.

Behaviour:
- Reset (asynchronous, any state, including mid-frame): FSM to IDLE; TX_OUT=1; Busy=0; bit and edge counters=0; data, parity-enable, parity-type and prescale holding registers cleared. No partial frame resumes after reset release.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: on a CLK edge in IDLE with Data_Valid=1:
  - latch P_DATA, PAR_EN, PAR_TYP and prescale;
  - move to START; TX_OUT=0 and Busy=1 from that same edge (1-cycle latency from Data_Valid sample to start bit on the line).
- Held settings: input changes during a frame have no effect on that frame.
- Data_Valid outside IDLE (Busy=1) is ignored. There is no queueing, and no error or flag is raised.
- Bit timing:
  - a 6-bit edge counter runs 0..P-1 in each of START/DATA/PARITY/STOP, where P = latched prescale;
  - at count P-1 the counter returns to 0 and the FSM advances or shifts to the next bit.
  - Latched prescale 0 means P=64 (natural 6-bit wrap). P=1 is legal: one cycle per bit.
- DATA state:
  - a bit counter 0..DATA_WIDTH-1 selects the bit; TX_OUT = data[bit_counter];
  - after bit DATA_WIDTH-1 completes, go to PARITY if PAR_EN=1, else STOP.
- PARITY: TX_OUT = (XOR of all latched data bits) XOR PAR_TYP. Held for P cycles, then STOP.
- STOP:
  - TX_OUT=1 for P cycles; on the edge ending the stop bit, FSM to IDLE and Busy=0.
  - A Data_Valid high on that same edge is ignored. The earliest next accept is the following edge, so the gap between frames is at least 1 idle clock.
- Frame length from accept to Busy falling: P*(DATA_WIDTH+2) cycles without parity; P*(DATA_WIDTH+3) cycles with parity.
- TX_OUT and Busy are driven straight from flops, with no combinational path from the inputs.
- Counter widths: bit counter is clog2(DATA_WIDTH) bits; edge counter is 6 bits. Neither counter wraps except as stated above.

Test Plan:
- Reset, then idle 20 cycles -> TX_OUT=1, Busy=0 throughout; Data_Valid=0 produces no activity.
- P_DATA=0xA5, PAR_EN=0, prescale=8, Data_Valid pulsed 1 cycle -> next edge TX_OUT=0 and Busy=1; line shows 0,1,0,1,0,0,1,0,1,1 with each bit exactly 8 cycles; Busy falls 80 cycles after accept.
- P_DATA=0x37, PAR_EN=1, PAR_TYP=0, prescale=16 -> parity bit=1 (five ones); frame 176 cycles. Repeat with PAR_TYP=1 -> parity bit=0.
- Mid-frame, change P_DATA to 0xFF, prescale to 32, and pulse Data_Valid -> current frame unchanged; no second frame starts; Busy timing unchanged.
- Data_Valid held high continuously with P_DATA=0x00, prescale=8 -> back-to-back frames with exactly 1 idle-high cycle between each stop bit and the next start bit.
- Assert RST during DATA bit 3 of a frame -> TX_OUT=1 and Busy=0 immediately (asynchronously). After release with Data_Valid=0, the line stays idle. A fresh request then yields a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer.
// Frames one parallel word per handshake as: start(0), data LSB first,
// optional parity, stop(1). Every bit is held for P clocks, where P is the
// prescale captured at accept (0 encodes 64). TX_OUT and Busy come straight
// from flops, so nothing on the input side can glitch the serial line.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int                BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            edge_q, edge_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  tx_d, busy_d;

  // Settings captured at accept; frozen for the whole frame.
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [5:0]            prescale_q;

  logic                  accept;
  logic                  bit_done;
  logic [BIT_W-1:0]      bit_inc;
  logic                  parity_bit;

  // Accept is only possible in IDLE, which also makes the stop-bit edge
  // (still in STOP) ignore Data_Valid and forces at least one idle clock.
  assign accept     = (state_q == IDLE) && Data_Valid;
  // prescale 0 makes P-1 wrap to 63, giving the 64-cycle bit for free.
  assign bit_done   = (edge_q == (prescale_q - 6'd1));
  assign bit_inc    = bit_q + BIT_ONE;
  assign parity_bit = (^data_q) ^ par_typ_q;

  // Next-state, counter and registered-output decode for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    tx_d    = TX_OUT;
    busy_d  = Busy;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        edge_d = 6'd0;
        bit_d  = '0;
        if (Data_Valid) begin
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (bit_done) begin
          edge_d  = 6'd0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = data_q[0];
        end else begin
          edge_d = edge_q + 6'd1;
        end
      end

      DATA: begin
        if (bit_done) begin
          edge_d = 6'd0;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = parity_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_inc;
            tx_d  = data_q[bit_inc];
          end
        end else begin
          edge_d = edge_q + 6'd1;
        end
      end

      PARITY: begin
        if (bit_done) begin
          edge_d  = 6'd0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          edge_d = edge_q + 6'd1;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          edge_d  = 6'd0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          edge_d = edge_q + 6'd1;
        end
      end

      default: begin
        state_d = IDLE;
        edge_d  = 6'd0;
        bit_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state, counters and the two line-facing output flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q  <= 6'd0;
      bit_q   <= '0;
      TX_OUT  <= 1'b1;
      Busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop in this block
      // sampling pre-edge values, independent of statement order.
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      TX_OUT  <= tx_d;
      Busy    <= busy_d;
    end
  end

  // Capture the frame settings on accept; hold them until the next accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: these holding registers are cleared on reset so a frame
      // aborted by reset leaves no stale word or prescale behind.
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= 6'd0;
    end else if (accept) begin
      data_q     <= P_DATA;
      par_en_q   <= PAR_EN;
      par_typ_q  <= PAR_TYP;
      prescale_q <= prescale;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a driver issues requests and pushes the
// expected frame into a queue; an independent monitor pops it on every
// rising Busy and checks the serial line cycle by cycle against a bit list
// built from the frame format.
module tb_uart_tx_serializer;

  localparam int DW     = 8;
  localparam int MAXBIT = DW + 3;

  logic          CLK        = 1'b0;
  logic          RST        = 1'b1;
  logic [DW-1:0] P_DATA     = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN     = 1'b0;
  logic          PAR_TYP    = 1'b0;
  logic [5:0]    prescale   = 6'd0;
  logic          TX_OUT;
  logic          Busy;

  uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] data;
    bit            par_en;
    bit            par_typ;
    int            p;
  } frame_t;

  frame_t exp_q[$];
  int     checks         = 0;
  int     errors         = 0;
  int     frames_started = 0;
  bit     in_frame       = 1'b0;
  bit     gap_check      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop an expected frame on each Busy rise and follow it to the end.
  initial begin : monitor
    frame_t e;
    logic   bits [MAXBIT];
    int     bad  [MAXBIT];
    int     nbits, total, cnt, gap, idle_bad, n;
    bit     prev_busy, aborted, done, odd_ones;
    prev_busy = 1'b0;
    gap       = 1000;
    idle_bad  = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_busy = 1'b0;
        in_frame  = 1'b0;
        gap       = 1000;
      end else if (Busy && !prev_busy) begin
        frames_started++;
        in_frame = 1'b1;
        if (gap_check) check("frame_gap", gap, 1);
        check("idle_line_high", idle_bad, 0);
        idle_bad = 0;
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          nbits = 0;
          bits[nbits++] = 1'b0;
          for (int i = 0; i < DW; i++) bits[nbits++] = e.data[i];
          if (e.par_en) begin
            odd_ones = ($countones(e.data) % 2) == 1;
            bits[nbits++] = e.par_typ ? !odd_ones : odd_ones;
          end
          bits[nbits++] = 1'b1;
          for (int i = 0; i < MAXBIT; i++) bad[i] = 0;
          total   = e.p * nbits;
          cnt     = 0;
          aborted = 1'b0;
          done    = 1'b0;
          while (!done) begin
            if (!RST) begin
              aborted = 1'b1;
              done    = 1'b1;
            end else if (!Busy || cnt > total) begin
              done = 1'b1;
            end else begin
              if (cnt < total && TX_OUT !== bits[cnt / e.p]) bad[cnt / e.p]++;
              cnt++;
              @(negedge CLK);
            end
          end
          if (!aborted) begin
            check($sformatf("busy_len_p%0d", e.p), cnt, total);
            for (int i = 0; i < nbits; i++)
              check($sformatf("line_bit%0d_data%0h", i, e.data), bad[i], 0);
          end
        end else begin
          n = 0;
          while (Busy && RST && n < 5000) begin
            @(negedge CLK);
            n++;
          end
        end
        in_frame  = 1'b0;
        prev_busy = Busy;
        if (RST && !Busy) begin
          gap      = 1;
          idle_bad = (TX_OUT !== 1'b1) ? 1 : 0;
        end else begin
          gap = 1000;
        end
      end else begin
        if (!Busy) begin
          gap++;
          if (TX_OUT !== 1'b1) idle_bad++;
        end
        prev_busy = Busy;
      end
    end
  end

  // Issue one request; afterwards scramble the inputs to prove they are held.
  task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt, input logic [5:0] ps);
    frame_t f;
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    prescale   = ps;
    Data_Valid = 1'b1;
    f.data     = d;
    f.par_en   = pe;
    f.par_typ  = pt;
    f.p        = (ps == 6'd0) ? 64 : int'(ps);
    exp_q.push_back(f);
    @(negedge CLK);
    Data_Valid = 1'b0;
    check("accept_start_bit", {30'd0, Busy, TX_OUT}, 32'd2);
    P_DATA   = DW'($urandom);
    prescale = 6'($urandom);
    PAR_EN   = 1'($urandom);
    PAR_TYP  = 1'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame || Busy) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check({"drain_", name}, n < budget, 1);
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (frames_started < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check({"frame_start_", name}, n < budget, 1);
  endtask

  initial begin : driver
    int bad, base;
    // Reset state.
    #2 RST = 1'b0;
    #1;
    check("rst_tx_out", TX_OUT, 1);
    check("rst_busy", Busy, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // Idle with no request.
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) bad++;
    end
    check("idle_no_request", bad, 0);

    // Plain frame, and parity frames of both types.
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    wait_done("a5", 200);
    send(8'h37, 1'b1, 1'b0, 6'd16);
    wait_done("37_even", 400);
    send(8'h37, 1'b1, 1'b1, 6'd16);
    wait_done("37_odd", 400);

    // Request and input changes mid-frame are ignored.
    send(8'h5A, 1'b1, 1'b1, 6'd8);
    repeat (20) @(negedge CLK);
    P_DATA     = 8'hFF;
    prescale   = 6'd32;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    wait_done("midframe", 300);
    base = frames_started;
    repeat (40) @(negedge CLK);
    check("no_second_frame", frames_started, base);

    // Data_Valid held: back-to-back frames, one idle clock apart.
    base = frames_started;
    for (int i = 0; i < 3; i++) begin
      frame_t f;
      f.data = 8'h00; f.par_en = 1'b0; f.par_typ = 1'b0; f.p = 8;
      exp_q.push_back(f);
    end
    @(negedge CLK);
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescale   = 6'd8;
    Data_Valid = 1'b1;
    wait_frames("b2b_first", base + 1, 50);
    gap_check = 1'b1;
    wait_frames("b2b_third", base + 3, 300);
    Data_Valid = 1'b0;
    wait_done("b2b", 300);
    gap_check = 1'b0;

    // Asynchronous reset during data bit 3 (bit 3 of 0xC3 is 0).
    send(8'hC3, 1'b0, 1'b0, 6'd4);
    repeat (17) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("async_rst_tx_out", TX_OUT, 1);
    check("async_rst_busy", Busy, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) bad++;
    end
    check("idle_after_async_rst", bad, 0);
    check("aborted_frame_consumed", exp_q.size(), 0);
    send(8'h96, 1'b1, 1'b0, 6'd3);
    wait_done("post_rst", 200);

    // Randomized frames, including P=1 and the prescale=0 (64) case.
    for (int i = 0; i < 10; i++) begin
      logic [5:0] ps;
      if (i == 3)      ps = 6'd0;
      else if (i == 5) ps = 6'd1;
      else             ps = 6'($urandom_range(1, 6));
      send(DW'($urandom), 1'($urandom), 1'($urandom), ps);
      wait_done($sformatf("rand%0d", i), 1000);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    repeat (5) @(negedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
